// File: rtl/regfile_param.sv
// regfile_param: parameterised register file with byte-enabled writes, optional
// write-to-read bypass, optional hard-zero register 0 and a DEPTH-cycle bulk clear.
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter bit ZERO_REG = 1,
    parameter bit BYPASS   = 1
) (
    input  logic               clock,
    input  logic               Reset_n,
    input  logic [AW-1:0]      Read1,
    input  logic [AW-1:0]      Read2,
    input  logic [AW-1:0]      WriteReg,
    input  logic [WIDTH-1:0]   WriteData,
    input  logic [WIDTH/8-1:0] ByteEn,
    input  logic               RegWrite,
    input  logic               Clear,
    output logic [WIDTH-1:0]   Data1,
    output logic [WIDTH-1:0]   Data2,
    output logic               Busy
);
    localparam int NB = WIDTH / 8;
    typedef enum logic {IDLE, CLEARING} state_t;
    state_t           r_state;
    logic [AW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_regs [DEPTH];
    logic             w_we;
    logic             w_byp1;
    logic             w_byp2;
    logic [WIDTH-1:0] w_merge;

    // Address exists and is not the hard-wired zero register
    function automatic logic writable(input logic [AW-1:0] a);
        return ({1'b0, a} < (AW+1)'(DEPTH)) && !(ZERO_REG && a == '0);
    endfunction

    assign Busy   = r_state == CLEARING;
    assign w_we   = RegWrite && !Busy && writable(WriteReg);
    assign w_byp1 = BYPASS && w_we && Read1 == WriteReg;
    assign w_byp2 = BYPASS && w_we && Read2 == WriteReg;
    assign Data1  = !writable(Read1) ? '0 : w_byp1 ? w_merge : r_regs[Read1];
    assign Data2  = !writable(Read2) ? '0 : w_byp2 ? w_merge : r_regs[Read2];

    always_comb begin
        w_merge = r_regs[WriteReg];
        for (int k = 0; k < NB; k++)
            if (ByteEn[k]) w_merge[8*k +: 8] = WriteData[8*k +: 8];
    end

    // Writes are only accepted in IDLE, so they never collide with the clear sweep
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else begin
            if (w_we) r_regs[WriteReg] <= w_merge;
            if (r_state == IDLE) begin
                if (Clear) begin
                    r_state <= CLEARING;
                    r_cnt   <= '0;
                end
            end else begin
                r_regs[r_cnt] <= '0;
                r_cnt         <= r_cnt + AW'(1);
                if (r_cnt == AW'(DEPTH - 1)) r_state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: scoreboard bench for regfile_param with bypass on/off and a 16x12 variant.
module tb_regfile_param;
    logic        clock;
    logic        Reset_n;
    logic [4:0]  Read1, Read2, WriteReg;
    logic [31:0] WriteData;
    logic [3:0]  ByteEn;
    logic        RegWrite, Clear;
    logic [31:0] Data1a, Data2a, Data1b, Data2b;
    logic        Busya, Busyb;
    logic [3:0]  c_r1, c_r2, c_wr;
    logic [15:0] c_wd, c_d1, c_d2;
    logic [1:0]  c_be;
    logic        c_we, c_clr, c_busy;
    logic [31:0] mdl [32];
    logic [31:0] q [$];
    int          n_chk = 0;
    int          n_pass = 0;

    regfile_param u_a (
        .clock(clock), .Reset_n(Reset_n), .Read1(Read1), .Read2(Read2), .WriteReg(WriteReg),
        .WriteData(WriteData), .ByteEn(ByteEn), .RegWrite(RegWrite), .Clear(Clear),
        .Data1(Data1a), .Data2(Data2a), .Busy(Busya));

    regfile_param #(.BYPASS(0)) u_b (
        .clock(clock), .Reset_n(Reset_n), .Read1(Read1), .Read2(Read2), .WriteReg(WriteReg),
        .WriteData(WriteData), .ByteEn(ByteEn), .RegWrite(RegWrite), .Clear(Clear),
        .Data1(Data1b), .Data2(Data2b), .Busy(Busyb));

    regfile_param #(.WIDTH(16), .DEPTH(12)) u_c (
        .clock(clock), .Reset_n(Reset_n), .Read1(c_r1), .Read2(c_r2), .WriteReg(c_wr),
        .WriteData(c_wd), .ByteEn(c_be), .RegWrite(c_we), .Clear(c_clr),
        .Data1(c_d1), .Data2(c_d2), .Busy(c_busy));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clock);
        WriteReg = a; WriteData = d; ByteEn = be; RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0; ByteEn = '0;
        if (a != 0) for (int k = 0; k < 4; k++) if (be[k]) mdl[a][8*k +: 8] = d[8*k +: 8];
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        Read1 = a1; Read2 = a2;
        q.push_back(mdl[a1]); q.push_back(mdl[a2]);
        q.push_back(mdl[a1]); q.push_back(mdl[a2]);
        #1;
        chk($sformatf("a.rd1[%0d]", a1), Data1a, q.pop_front());
        chk($sformatf("a.rd2[%0d]", a2), Data2a, q.pop_front());
        chk($sformatf("b.rd1[%0d]", a1), Data1b, q.pop_front());
        chk($sformatf("b.rd2[%0d]", a2), Data2b, q.pop_front());
    endtask

    initial begin
        Reset_n = 1'b0; Read1 = '0; Read2 = '0; WriteReg = '0; WriteData = '0; ByteEn = '0;
        RegWrite = 1'b0; Clear = 1'b0;
        c_r1 = '0; c_r2 = '0; c_wr = '0; c_wd = '0; c_be = '0; c_we = 1'b0; c_clr = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        #1;
        chk("rst_busy", 32'(Busya), 32'd0);
        rd(0, 1);
        repeat (2) @(posedge clock);
        #3 Reset_n = 1'b1;

        for (int i = 1; i < 32; i++) wr(5'(i), 32'hA500_0000 + i, 4'hF);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(i + 1));
            tick();
        end

        wr(5, 32'h1122_3344, 4'hF);
        wr(5, 32'hAABB_CCDD, 4'h5);
        rd(5, 5);
        chk("merge", Data1a, 32'h11BB_33DD);
        wr(6, 32'hFFFF_FFFF, 4'h0);
        rd(6, 6);

        wr(7, 32'h0, 4'hF);
        @(negedge clock);
        Read1 = 7; Read2 = 7; WriteReg = 7; WriteData = 32'hDEAD_BEEF; ByteEn = 4'hF; RegWrite = 1'b1;
        #1;
        chk("byp_a1", Data1a, 32'hDEAD_BEEF);
        chk("byp_a2", Data2a, 32'hDEAD_BEEF);
        chk("nobyp_pre", Data1b, 32'h0);
        tick();
        RegWrite = 1'b0; mdl[7] = 32'hDEAD_BEEF;
        chk("nobyp_post", Data1b, 32'hDEAD_BEEF);
        @(negedge clock);
        WriteData = 32'h1122_3344; ByteEn = 4'h3; RegWrite = 1'b1;
        #1;
        chk("byp_part", Data1a, 32'hDEAD_3344);
        chk("nobyp_part", Data1b, 32'hDEAD_BEEF);
        tick();
        RegWrite = 1'b0; mdl[7] = 32'hDEAD_3344;
        rd(7, 7);
        @(negedge clock);
        Read1 = 0; WriteReg = 0; WriteData = 32'hFFFF_FFFF; ByteEn = 4'hF; RegWrite = 1'b1;
        #1;
        chk("byp_zero", Data1a, 32'h0);
        tick();
        RegWrite = 1'b0;
        rd(0, 0);

        for (int i = 1; i < 32; i++) wr(5'(i), 32'h1000 + i, 4'hF);
        chk("busy_pre", 32'(Busya), 32'd0);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) mdl[k-1] = '0;
            chk($sformatf("busy%0d", k), 32'(Busya), 32'd1);
            if (k == 2) begin
                Read1 = 3; WriteReg = 3; WriteData = 32'hFFFF_FFFF; ByteEn = 4'hF; RegWrite = 1'b1;
                q.push_back(mdl[3]);
                #1 chk("busy_nobyp", Data1a, q.pop_front());
            end
            if (k == 3) rd(3, 2);
            if (k == 10) rd(9, 20);
            Clear = (k == 15);
            tick();
            RegWrite = 1'b0;
        end
        mdl[31] = '0;
        chk("busy_end", 32'(Busya), 32'd0);
        for (int i = 0; i < 32; i += 2) rd(5'(i), 5'(i + 1));

        @(negedge clock);
        WriteReg = 8; WriteData = 32'h55; ByteEn = 4'hF; RegWrite = 1'b1; Clear = 1'b1;
        tick();
        RegWrite = 1'b0; Clear = 1'b0; mdl[8] = 32'h55;
        chk("wc_busy", 32'(Busya), 32'd1);
        rd(8, 0);
        repeat (32) tick();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        chk("wc_done", 32'(Busya), 32'd0);
        rd(8, 1);

        wr(4, 32'h77, 4'hF);
        wr(20, 32'h1234, 4'hF);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        repeat (12) tick();
        Read1 = 20; Read2 = 4;
        #2 Reset_n = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        #1 chk("abort_busy", 32'(Busya), 32'd0);
        rd(20, 4);
        @(negedge clock);
        Reset_n = 1'b1;
        wr(4, 32'h1, 4'hF);
        rd(4, 20);

        @(negedge clock);
        c_wr = 5; c_wd = 16'h5555; c_be = 2'b11; c_we = 1'b1;
        tick();
        c_wr = 11; c_wd = 16'hBEEF;
        tick();
        c_wr = 13; c_wd = 16'h1234;
        tick();
        c_we = 1'b0;
        c_r1 = 13; c_r2 = 11;
        q.push_back(32'h0); q.push_back(32'hBEEF);
        #1;
        chk("c_rd13", 32'(c_d1), q.pop_front());
        chk("c_rd11", 32'(c_d2), q.pop_front());
        c_r1 = 5; c_r2 = 12;
        q.push_back(32'h5555); q.push_back(32'h0);
        #1;
        chk("c_rd5", 32'(c_d1), q.pop_front());
        chk("c_rd12", 32'(c_d2), q.pop_front());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
